encoder_8_3: RTL and testbench

Registered 8-to-3 priority encoder with request capture and a valid/ack handshake; the companion of the 3-to-8 decode path. It latches request pulses or levels on eight lines into a pending register and presents the index of the highest-numbered pending line on `Out`. That index is held stable until the consumer acknowledges it. It sits in front of `decoder_3_8` consumers, so an acknowledged `Out` can be fed straight back through the decoder to select or clear the winning line.

---
 rtl/encoder_8_3_if.sv | 31 +++
 rtl/encoder_8_3.sv | 118 +++++++++++
 tb/tb_encoder_8_3.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/encoder_8_3_if.sv
// Request/grant bundle between a requester-consumer and encoder_8_3.
// The master drives enable, requests and ack; the slave (encoder) returns the grant.
interface encoder_8_3_if;
  logic       E;
  logic [7:0] In;
  logic       ack;
  logic [2:0] Out;
  logic       valid;
  logic [7:0] pending;
  logic       dropped;

  modport master (
    output E,
    output In,
    output ack,
    input  Out,
    input  valid,
    input  pending,
    input  dropped
  );

  modport slave (
    input  E,
    input  In,
    input  ack,
    output Out,
    output valid,
    output pending,
    output dropped
  );
endinterface

// File: rtl/encoder_8_3.sv
// Registered 8-to-3 priority encoder with request capture and valid/ack handshake.
// Define ENC_EDGE_DETECT_EN for rising-edge capture; default build captures levels.
module encoder_8_3 (
  input  logic          clk,
  input  logic          rst_n,
  encoder_8_3_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       issue_s;
  logic       ack_take_s;
  logic [7:0] cap_s;
  logic [7:0] clr_s;
  logic [7:0] pending_r;
  logic [2:0] out_r;
  logic       valid_r;
  logic       dropped_r;

  // Highest set bit wins: later iterations overwrite earlier ones.
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

`ifdef ENC_EDGE_DETECT_EN
  logic [7:0] in_d_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d_r <= 8'h00;
    end else begin
      in_d_r <= bus.In;
    end
  end
`endif

  always_comb begin
    cap_s = 8'h00;
    if (bus.E) begin
`ifdef ENC_EDGE_DETECT_EN
      cap_s = bus.In & ~in_d_r;
`else
      cap_s = bus.In;
`endif
    end else begin
      cap_s = 8'h00;
    end
  end

  assign ack_take_s = (state_r == HOLD) && bus.ack;
  assign clr_s      = ack_take_s ? one_hot(out_r) : 8'h00;

  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.E && (pending_r != 8'h00)) begin
          state_nxt_s = HOLD;
          issue_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          state_nxt_s = RETIRE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      RETIRE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Set wins over clear, so a re-asserted line survives its own ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= 8'h00;
      out_r     <= 3'd0;
      valid_r   <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= (pending_r & ~clr_s) | cap_s;
      dropped_r <= |(cap_s & pending_r & ~clr_s);
      valid_r   <= (state_nxt_s == HOLD);
      if (issue_s) begin
        out_r <= prio_idx(pending_r);
      end
    end
  end

  assign bus.Out     = out_r;
  assign bus.valid   = valid_r;
  assign bus.pending = pending_r;
  assign bus.dropped = dropped_r;

endmodule

// File: tb/tb_encoder_8_3.sv
// Self-checking bench for encoder_8_3: directed vector table, reset and hold
// sequences, then random traffic against a behavioural grant model.
module tb_encoder_8_3;

  logic clk;
  logic rst_n;
  encoder_8_3_if bus ();

  encoder_8_3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic [7:0] in;
    logic       ack;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pend;
    logic       drop;
  } vec_t;

  vec_t tbl [34];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending set, current grant index (-1 = none), retire gap.
  logic [7:0] m_pend;
  logic [7:0] m_in_prev;
  logic [2:0] m_out;
  logic       m_drop;
  int         m_grant;
  int         m_gap;

  task automatic model_reset();
    m_pend = 8'h00; m_in_prev = 8'h00; m_out = 3'd0; m_drop = 1'b0;
    m_grant = -1; m_gap = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] in, input logic a);
    logic [7:0] cap;
    logic [7:0] clr;
    clr = 8'h00;
`ifdef ENC_EDGE_DETECT_EN
    cap = e ? (in & ~m_in_prev) : 8'h00;
`else
    cap = e ? in : 8'h00;
`endif
    if (m_grant >= 0) begin
      if (a) begin
        clr[m_grant] = 1'b1;
        m_grant = -1;
        m_gap = 1;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (e && m_pend != 8'h00) begin
      for (int i = 7; i >= 0; i--) begin
        if (m_pend[i]) begin
          m_grant = i;
          break;
        end
      end
      m_out = 3'(m_grant);
    end
    m_drop    = |(cap & m_pend & ~clr);
    m_pend    = (m_pend & ~clr) | cap;
    m_in_prev = in;
  endtask

  function automatic logic [12:0] model_vec();
    return {m_out, (m_grant >= 0), m_pend, m_drop};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.Out, bus.valid, bus.pending, bus.dropped};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got Out/valid/pending/dropped=%h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic e, input logic [7:0] in, input logic a);
    bus.E = e; bus.In = in; bus.ack = a;
    model_step(e, in, a);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic [7:0] in, input logic a,
                              input logic [2:0] o, input logic v, input logic [7:0] p,
                              input logic d);
    vec_t r;
    r.e = e; r.in = in; r.ack = a; r.out = o; r.valid = v; r.pend = p; r.drop = d;
    return r;
  endfunction

  initial begin
    int grants;
    int drops;
    logic pend1_lost;
    logic prev_valid;

    tbl[0]  = mk(1'b1, 8'h24, 1'b0, 3'd0, 1'b0, 8'h24, 1'b0);
    tbl[1]  = mk(1'b1, 8'h00, 1'b0, 3'd5, 1'b1, 8'h24, 1'b0);
    tbl[2]  = mk(1'b1, 8'h00, 1'b1, 3'd5, 1'b0, 8'h04, 1'b0);
    tbl[3]  = mk(1'b1, 8'h00, 1'b0, 3'd5, 1'b0, 8'h04, 1'b0);
    tbl[4]  = mk(1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0);
    tbl[5]  = mk(1'b1, 8'h80, 1'b0, 3'd2, 1'b1, 8'h84, 1'b0);
    tbl[6]  = mk(1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 8'h84, 1'b0);
    tbl[7]  = mk(1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 8'h80, 1'b0);
    tbl[8]  = mk(1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 8'h80, 1'b0);
    tbl[9]  = mk(1'b1, 8'h00, 1'b0, 3'd7, 1'b1, 8'h80, 1'b0);
    tbl[10] = mk(1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    tbl[11] = mk(1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    tbl[12] = mk(1'b0, 8'h01, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0);
    tbl[13] = mk(1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0);
    tbl[14] = mk(1'b1, 8'h10, 1'b0, 3'd7, 1'b0, 8'h10, 1'b0);
    tbl[15] = mk(1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 8'h10, 1'b0);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 8'h10, 1'b0);
    tbl[17] = mk(1'b1, 8'h00, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0);
    tbl[18] = mk(1'b1, 8'h08, 1'b0, 3'd4, 1'b1, 8'h18, 1'b0);
    tbl[19] = mk(1'b1, 8'h00, 1'b0, 3'd4, 1'b1, 8'h18, 1'b0);
    tbl[20] = mk(1'b1, 8'h08, 1'b0, 3'd4, 1'b1, 8'h18, 1'b1);
    tbl[21] = mk(1'b1, 8'h00, 1'b0, 3'd4, 1'b1, 8'h18, 1'b0);
    tbl[22] = mk(1'b1, 8'h80, 1'b1, 3'd4, 1'b0, 8'h88, 1'b0);
    tbl[23] = mk(1'b1, 8'h00, 1'b0, 3'd4, 1'b0, 8'h88, 1'b0);
    tbl[24] = mk(1'b1, 8'h00, 1'b0, 3'd7, 1'b1, 8'h88, 1'b0);
    tbl[25] = mk(1'b1, 8'h80, 1'b1, 3'd7, 1'b0, 8'h88, 1'b0);
    tbl[26] = mk(1'b1, 8'h00, 1'b0, 3'd7, 1'b0, 8'h88, 1'b0);
    tbl[27] = mk(1'b1, 8'h00, 1'b0, 3'd7, 1'b1, 8'h88, 1'b0);
    tbl[28] = mk(1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h08, 1'b0);
    tbl[29] = mk(1'b1, 8'h00, 1'b0, 3'd7, 1'b0, 8'h08, 1'b0);
    tbl[30] = mk(1'b1, 8'h00, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0);
    tbl[31] = mk(1'b1, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0);
    tbl[32] = mk(1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0);
    tbl[33] = mk(1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0);

    rst_n = 1'b0; bus.E = 1'b0; bus.In = 8'h00; bus.ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 13'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      cycle(tbl[i].e, tbl[i].in, tbl[i].ack);
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].out, tbl[i].valid, tbl[i].pend, tbl[i].drop});
    end

    // Asynchronous reset in the middle of a HOLD on index 7.
    cycle(1'b1, 8'h81, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    check("hold_before_reset", dut_vec(), {3'd7, 1'b1, 8'h81, 1'b0});
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 13'h0000);
    bus.E = 1'b0; bus.In = 8'h00; bus.ack = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Line 1 held high with every grant acked.
    grants = 0; drops = 0; pend1_lost = 1'b0; prev_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 8'h02, (m_grant >= 0));
      check($sformatf("hold_c%0d", c), dut_vec(), model_vec());
      if (bus.valid && !prev_valid && bus.Out == 3'd1) grants++;
      if (bus.dropped) drops++;
      if (c > 0 && !bus.pending[1]) pend1_lost = 1'b1;
      prev_valid = bus.valid;
    end
`ifdef ENC_EDGE_DETECT_EN
    check("hold_grants", 13'(grants), 13'd1);
    check("hold_drops", 13'(drops), 13'd0);
`else
    check("hold_grants", 13'(grants), 13'd4);
    check("hold_drops", 13'(drops), 13'd7);
    check("hold_pend1_kept", {12'd0, pend1_lost}, 13'd0);
`endif
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, (m_grant >= 0));
    repeat (4) cycle(1'b1, 8'h00, (m_grant >= 0));

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic       e;
      logic [7:0] in;
      logic       a;
      e  = ($urandom_range(0, 7) != 0);
      in = 8'($urandom & $urandom & $urandom);
      a  = ($urandom_range(0, 2) == 0);
      cycle(e, in, a);
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
